bp_cce_gad_dir_seq: RTL
=======================

Name: bp_cce_gad_dir_seq

Overview:
Sequences a coherence-directory way-group read for the GAD stage of the CCE. It accepts a lookup request and issues one directory RAM row read per group of LCEs. It compares each returned entry against the request tag and consolidates the results into per-LCE hit/way/state vectors. It presents these to GAD with a valid/yumi handshake; gad_v_o is asserted while the result is valid.

Parameters:
num_lce_p, 8, number of LCEs tracked per way-group
lce_assoc_p, 8, ways per LCE set
lces_per_row_p, 2, LCE sets per directory RAM row; must divide num_lce_p
tag_width_p, 12, directory tag width
row_addr_width_p, 10, directory RAM row address width
(derived) rows_lp = num_lce_p/lces_per_row_p; entry_width_lp = tag_width_p+3; row_width_lp = lces_per_row_p*lce_assoc_p*entry_width_lp

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
req_v_i  in  1  lookup request valid
req_ready_o  out  1  block can accept a request (state IDLE)
req_tag_i  in  tag_width_p  tag to match
req_row_base_i  in  row_addr_width_p  first RAM row of way-group
ram_v_o  out  1  RAM read request
ram_ready_i  in  1  RAM accepts read this cycle
ram_addr_o  out  row_addr_width_p  RAM row address
ram_data_i  in  row_width_lp  row data, valid exactly 1 cycle after accepted read; LCE j at [j*lce_assoc_p*entry_width_lp], way w within LCE; entry = {tag, state[2:0]}
sharers_v_o  out  1  consolidated result valid
sharers_hits_o  out  num_lce_p  per-LCE hit
sharers_ways_o  out  num_lce_p*clog2(lce_assoc_p)  per-LCE hit way
sharers_coh_states_o  out  num_lce_p*3  per-LCE state (bp_coh_states_e)
gad_v_o  out  1  GAD op valid; equals sharers_v_o
yumi_i  in  1  consumer takes result; legal only when sharers_v_o=1
multi_hit_o  out  1  some LCE matched on more than one valid way during this lookup

Behaviour:
- Reset (async assert, sync deassert): state IDLE. req_ready_o=1. ram_v_o=0. ram_addr_o=0. sharers_v_o=gad_v_o=0. All hits/ways/multi_hit=0. States=e_COH_I. Issue/capture counters=0. rd_pending=0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: req_ready_o=1. On req_v_i: latch tag and row_base, clear hits/ways/states/multi_hit, set issue_cnt=capture_cnt=0, go to READ.
- READ: ram_v_o=1, ram_addr_o=row_base+issue_cnt (mod 2^row_addr_width_p; wrap is legal). On ram_ready_i: issue_cnt++, rd_pending<=1 next cycle. If not ready, hold the address. The last accepted issue (issue_cnt=rows_lp-1) moves to DRAIN.
- Capture (any state): if rd_pending, ram_data_i is row capture_cnt. For each LCE j in the row, LCE index = capture_cnt*lces_per_row_p+j. Hit = any way with tag==req_tag and state!=e_COH_I. On a hit, the lowest such way index wins; record way and state. On no hit: hit=0, way=0, state=I. If more than one way hits, set multi_hit. Then capture_cnt++. rd_pending clears unless a new read is accepted the same cycle.
- DRAIN: ram_v_o=0. When the final row is captured, go to DONE.
- DONE: sharers_v_o=gad_v_o=1. Outputs are held stable. On yumi_i, go to IDLE; the vectors keep their values until the next accept. req_v_i is ignored in DONE (req_ready_o=0).
- Back-to-back ready: request accepted at cycle 0; reads at cycles 1..rows_lp; sharers_v_o at cycle rows_lp+2 (6 for defaults).
- Each stall cycle adds exactly 1 cycle of latency.
- Reset mid-lookup: abort immediately. Any outstanding RAM data is ignored.
- yumi_i while sharers_v_o=0: illegal; assert in simulation. The RTL ignores it.

Test Plan:
- Defaults, ram_ready_i=1, LCE3 way5 tag=0x0AB state M, all others I; req_tag=0x0AB, row_base=0x010 -> ram_addr 0x010..0x013 on cycles 1-4; sharers_v_o at cycle 6; hits=0x08, way[3]=5, state[3]=M, multi_hit_o=0.
- Tag match with state I in LCE0 way2 -> hits[0]=0, state[0]=I, way[0]=0.
- LCE6 matches on ways 1 and 4 (both S) -> way[6]=1, multi_hit_o=1.
- ram_ready_i low for 3 cycles on the row 2 read -> ram_addr_o holds row_base+2; sharers_v_o at cycle 9; results are identical to the unstalled run.
- row_base=0x3FE -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- reset_n_i asserted during READ, then a new request -> prior data is not visible; new result is correct; yumi_i held off 5 cycles in DONE keeps the outputs stable and req_ready_o=0.

Source files
------------

// File: rtl/bp_cce_gad_dir_seq.sv
// Directory way-group read sequencer for the CCE GAD stage: one RAM row read
// per group of LCEs, consolidated into per-LCE hit/way/state vectors.
module bp_cce_gad_dir_seq #(
  parameter int num_lce_p        = 8,
  parameter int lce_assoc_p      = 8,
  parameter int lces_per_row_p   = 2,
  parameter int tag_width_p      = 12,
  parameter int row_addr_width_p = 10
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 req_v_i,
  output logic                                 req_ready_o,
  input  logic [tag_width_p-1:0]               req_tag_i,
  input  logic [row_addr_width_p-1:0]          req_row_base_i,
  output logic                                 ram_v_o,
  input  logic                                 ram_ready_i,
  output logic [row_addr_width_p-1:0]          ram_addr_o,
  input  logic [lces_per_row_p*lce_assoc_p*(tag_width_p+3)-1:0] ram_data_i,
  output logic                                 sharers_v_o,
  output logic [num_lce_p-1:0]                 sharers_hits_o,
  output logic [num_lce_p*$clog2(lce_assoc_p)-1:0] sharers_ways_o,
  output logic [num_lce_p*3-1:0]               sharers_coh_states_o,
  output logic                                 gad_v_o,
  input  logic                                 yumi_i,
  output logic                                 multi_hit_o
);

  localparam int rows_lp        = num_lce_p / lces_per_row_p;
  localparam int entry_width_lp = tag_width_p + 3;
  localparam int way_w_lp       = $clog2(lce_assoc_p);
  localparam int cnt_w_lp       = (rows_lp > 1) ? $clog2(rows_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_row_lp = cnt_w_lp'(rows_lp - 1);
  localparam logic [2:0] e_COH_I = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [tag_width_p-1:0]         tag_q;
  logic [row_addr_width_p-1:0]    base_q;
  logic [cnt_w_lp-1:0]            issue_cnt_q;
  logic [cnt_w_lp-1:0]            capture_cnt_q;
  logic                           rd_pending_q;
  logic [num_lce_p-1:0]           hits_q;
  logic [num_lce_p-1:0][way_w_lp-1:0] ways_q;
  logic [num_lce_p-1:0][2:0]      states_q;
  logic                           multi_q;

  logic [num_lce_p-1:0]           c_hit;
  logic [num_lce_p-1:0]           c_multi;
  logic [num_lce_p-1:0][way_w_lp-1:0] c_way;
  logic [num_lce_p-1:0][2:0]      c_st;
  logic [num_lce_p-1:0]           c_sel;
  logic                           row_multi;

  // Per-LCE match against whichever row slot that LCE occupies; lowest way wins.
  always_comb begin
    row_multi = 1'b0;
    for (int i = 0; i < num_lce_p; i++) begin
      c_hit[i]   = 1'b0;
      c_multi[i] = 1'b0;
      c_way[i]   = '0;
      c_st[i]    = e_COH_I;
      c_sel[i]   = rd_pending_q
                 && (capture_cnt_q == cnt_w_lp'(i / lces_per_row_p));
      for (int w = 0; w < lce_assoc_p; w++) begin
        if (ram_data_i[((i % lces_per_row_p) * lce_assoc_p + w) * entry_width_lp + 3
                       +: tag_width_p] == tag_q
            && ram_data_i[((i % lces_per_row_p) * lce_assoc_p + w) * entry_width_lp
                          +: 3] != e_COH_I) begin
          if (c_hit[i]) begin
            c_multi[i] = 1'b1;
          end else begin
            c_hit[i] = 1'b1;
            c_way[i] = way_w_lp'(w);
            c_st[i]  = ram_data_i[((i % lces_per_row_p) * lce_assoc_p + w)
                                  * entry_width_lp +: 3];
          end
        end
      end
      if (c_sel[i] && c_multi[i]) row_multi = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_v_i) state_d = READ;
      READ:  if (ram_ready_i && issue_cnt_q == last_row_lp) state_d = DRAIN;
      DRAIN: if (rd_pending_q && capture_cnt_q == last_row_lp) state_d = DONE;
      DONE:  if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      capture_cnt_q <= '0;
      rd_pending_q  <= 1'b0;
      hits_q        <= '0;
      ways_q        <= '0;
      states_q      <= '0;
      multi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= (state_q == READ) && ram_ready_i;
      if (state_q == IDLE && req_v_i) begin
        tag_q         <= req_tag_i;
        base_q        <= req_row_base_i;
        issue_cnt_q   <= '0;
        capture_cnt_q <= '0;
        hits_q        <= '0;
        ways_q        <= '0;
        states_q      <= '0;
        multi_q       <= 1'b0;
      end else begin
        if (state_q == READ && ram_ready_i) begin
          issue_cnt_q <= issue_cnt_q + cnt_w_lp'(1);
        end
        if (rd_pending_q) begin
          capture_cnt_q <= capture_cnt_q + cnt_w_lp'(1);
          multi_q       <= multi_q | row_multi;
          for (int i = 0; i < num_lce_p; i++) begin
            if (c_sel[i]) begin
              hits_q[i]   <= c_hit[i];
              ways_q[i]   <= c_way[i];
              states_q[i] <= c_st[i];
            end
          end
        end
      end
    end
  end

  assign req_ready_o          = (state_q == IDLE);
  assign ram_v_o              = (state_q == READ);
  assign ram_addr_o           = base_q + row_addr_width_p'(issue_cnt_q);
  assign sharers_v_o          = (state_q == DONE);
  assign gad_v_o              = sharers_v_o;
  assign sharers_hits_o       = hits_q;
  assign sharers_ways_o       = ways_q;
  assign sharers_coh_states_o = states_q;
  assign multi_hit_o          = multi_q;

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> sharers_v_o
  );

endmodule
